// File: rtl/circuito_exp6_pkg.sv
// circuito_exp6_pkg: state codes, sequence ROM and counter width for the Genius game core
package circuito_exp6_pkg;
  localparam int CW = 4;
  localparam logic [3:0] INICIAL     = 4'd0;
  localparam logic [3:0] PREPARACAO  = 4'd1;
  localparam logic [3:0] INICIA_SEQ  = 4'd2;
  localparam logic [3:0] REGISTRA    = 4'd4;
  localparam logic [3:0] COMPARACAO  = 4'd5;
  localparam logic [3:0] PROX_JOGADA = 4'd6;
  localparam logic [3:0] PROX_SEQ    = 4'd7;
  localparam logic [3:0] ESPERA      = 4'd9;
  localparam logic [3:0] FIM_GANHOU  = 4'd10;
  localparam logic [3:0] FIM_PERDEU  = 4'd11;
  localparam logic [3:0] FIM_TIMEOUT = 4'd12;
  // Listed from entry 15 down to entry 0
  localparam logic [15:0][3:0] ROM = {
    4'h4, 4'h1, 4'h8, 4'h8, 4'h4, 4'h4, 4'h2, 4'h2,
    4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1
  };
endpackage

// File: rtl/hexa7seg.sv
// hexa7seg: 4-bit value to active-low 7-segment pattern (gfedcba)
module hexa7seg (
  input  logic [3:0] hexa,
  output logic [6:0] display
);
  localparam logic [15:0][6:0] SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  assign display = SEG[hexa];
endmodule

// File: rtl/circuito_exp6_genius.sv
// circuito_exp6_genius: Genius memory game datapath + control with debug outputs
// Optional inactivity timeout (state 12) enabled by defining TIMEOUT_EN.
module circuito_exp6_genius
  import circuito_exp6_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic [3:0] leds,
  output logic       db_igual,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_sequencia,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_fimseq,
  output logic       db_igualseq,
  output logic       db_igualjogada,
  output logic       db_tem_jogada,
  output logic       db_timeout
);
  logic [3:0] estado, prox;
  logic [CW-1:0] endereco, limite;
  logic [3:0] jogada, memoria;
  logic tem_ant, jogada_feita, tmo;
  assign memoria        = ROM[endereco];
  assign db_tem_jogada  = |botoes;
  assign jogada_feita   = db_tem_jogada & ~tem_ant;
  assign db_igualjogada = jogada == memoria;
  assign db_igualseq    = endereco == limite;
  assign db_fimseq      = limite == CW'(15);
  assign db_igual       = db_igualjogada;
  assign db_clock       = clock;
  assign db_iniciar     = jogar;
  assign db_estado      = {3'b000, estado};
  assign db_timeout     = tmo;
  assign leds           = jogada;
  assign ganhou         = estado == FIM_GANHOU;
  assign perdeu         = estado == FIM_PERDEU || estado == FIM_TIMEOUT;
  assign pronto         = ganhou | perdeu;
`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clock)
    tcnt <= (reset || estado != ESPERA) ? '0 : tcnt + 1'b1;
  // Flag stays high in the timeout end state so the board shows why the game ended
  assign tmo = (estado == ESPERA && tcnt == TW'(TIMEOUT_CICLOS - 1)) || estado == FIM_TIMEOUT;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CICLOS;
  assign tmo = 1'b0;
`endif
  always_comb begin
    prox = INICIAL;
    case (estado)
      INICIAL:     prox = jogar ? PREPARACAO : INICIAL;
      PREPARACAO:  prox = INICIA_SEQ;
      INICIA_SEQ:  prox = ESPERA;
      ESPERA:      prox = jogada_feita ? REGISTRA : tmo ? FIM_TIMEOUT : ESPERA;
      REGISTRA:    prox = COMPARACAO;
      COMPARACAO:  prox = !db_igualjogada ? FIM_PERDEU :
                          db_igualseq ? (db_fimseq ? FIM_GANHOU : PROX_SEQ) : PROX_JOGADA;
      PROX_JOGADA: prox = ESPERA;
      PROX_SEQ:    prox = INICIA_SEQ;
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: prox = jogar ? PREPARACAO : estado;
      default:     prox = INICIAL;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= INICIAL;
      endereco <= '0;
      limite   <= '0;
      jogada   <= '0;
      tem_ant  <= 1'b0;
    end else begin
      estado   <= prox;
      tem_ant  <= db_tem_jogada;
      endereco <= (estado == PREPARACAO || estado == INICIA_SEQ) ? '0 :
                  estado == PROX_JOGADA ? endereco + 1'b1 : endereco;
      limite   <= estado == PREPARACAO ? '0 : estado == PROX_SEQ ? limite + 1'b1 : limite;
      jogada   <= estado == PREPARACAO ? '0 : estado == REGISTRA ? botoes : jogada;
    end
  end
  hexa7seg u_contagem (.hexa(endereco), .display(db_contagem));
  hexa7seg u_memoria  (.hexa(memoria),  .display(db_memoria));
  hexa7seg u_jogada   (.hexa(jogada),   .display(db_jogadafeita));
  hexa7seg u_sequencia(.hexa(limite),   .display(db_sequencia));
endmodule

// File: tb/tb_circuito_exp6_genius.sv
// tb_circuito_exp6_genius: directed game scenarios checked through an expectation queue
module tb_circuito_exp6_genius;
  logic clock = 1'b0, reset = 1'b1, jogar = 1'b0;
  logic [3:0] botoes = 4'h0;
  logic ganhou, perdeu, pronto, db_igual, db_clock, db_iniciar, db_fimseq;
  logic db_igualseq, db_igualjogada, db_tem_jogada, db_timeout;
  logic [3:0] leds;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_sequencia;
  int n_chk = 0, n_fail = 0;

  circuito_exp6_genius #(.TIMEOUT_CICLOS(5000)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .leds(leds),
    .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
    .db_estado(db_estado), .db_jogadafeita(db_jogadafeita), .db_sequencia(db_sequencia),
    .db_clock(db_clock), .db_iniciar(db_iniciar), .db_fimseq(db_fimseq),
    .db_igualseq(db_igualseq), .db_igualjogada(db_igualjogada),
    .db_tem_jogada(db_tem_jogada), .db_timeout(db_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      nm;
    logic [6:0] st;
    logic       full;
    logic [3:0] leds;
    logic [2:0] gpr;
    logic [6:0] seq;
    logic [6:0] cnt;
    logic       to;
  } exp_t;
  exp_t q[$];

  logic [3:0] seq_rom [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                               4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b1000000; 4'h1: seg = 7'b1111001; 4'h2: seg = 7'b0100100; 4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001; 4'h5: seg = 7'b0010010; 4'h6: seg = 7'b0000010; 4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000; 4'h9: seg = 7'b0010000; 4'hA: seg = 7'b0001000; 4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110; 4'hD: seg = 7'b0100001; 4'hE: seg = 7'b0000110; default: seg = 7'b0001110;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_st(input string nm, input logic [3:0] st);
    exp_t e;
    e.nm = nm; e.st = {3'b000, st}; e.full = 1'b0;
    e.leds = '0; e.gpr = '0; e.seq = '0; e.cnt = '0; e.to = 1'b0;
    q.push_back(e);
  endtask

  // gpr = {ganhou, perdeu, pronto}
  task automatic push_all(input string nm, input logic [3:0] st, input logic [3:0] l,
                          input logic [2:0] gpr, input logic [3:0] sq, input logic [3:0] ct,
                          input logic to);
    exp_t e;
    e.nm = nm; e.st = {3'b000, st}; e.full = 1'b1;
    e.leds = l; e.gpr = gpr; e.seq = seg(sq); e.cnt = seg(ct); e.to = to;
    q.push_back(e);
  endtask

  task automatic press(input logic [3:0] b);
    botoes = b;
    tick(10);
    botoes = 4'h0;
    tick(10);
  endtask

  initial begin : monitor
    exp_t e;
    bit ok;
    forever begin
      @(negedge clock);
      while (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        ok = db_estado === e.st;
        if (e.full)
          ok = ok && leds === e.leds && {ganhou, perdeu, pronto} === e.gpr &&
               db_sequencia === e.seq && db_contagem === e.cnt && db_timeout === e.to;
        if (!ok) begin
          n_fail++;
          $display("FAIL %s: got estado=%0d leds=%h gpr=%b seq=%b cnt=%b to=%b; want estado=%0d leds=%h gpr=%b seq=%b cnt=%b to=%b",
                   e.nm, db_estado, leds, {ganhou, perdeu, pronto}, db_sequencia, db_contagem, db_timeout,
                   e.st, e.leds, e.gpr, e.seq, e.cnt, e.to);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(1);
    reset = 1'b0;
    push_all("reset", 4'd0, 4'h0, 3'b000, 4'h0, 4'h0, 1'b0);
    tick(2);
    push_st("idle_hold", 4'd0);
    jogar = 1'b1;
    tick(1); push_st("start_prep", 4'd1);
    tick(1); push_st("start_seq", 4'd2);
    tick(1); push_all("start_wait", 4'd9, 4'h0, 3'b000, 4'h0, 4'h0, 1'b0);
    tick(2);
    jogar = 1'b0;
    tick(1);
    push_st("jogar_ignored_in_wait", 4'd9);
    // first press: edge observed one cycle later, then registra/comparacao
    botoes = 4'h1;
    tick(1); push_st("press_registra", 4'd4);
    tick(1); push_st("press_compara", 4'd5);
    tick(1); push_st("press_prox_seq", 4'd7);
    tick(7);
    botoes = 4'h0;
    tick(10);
    push_all("round0_done", 4'd9, 4'h1, 3'b000, 4'h1, 4'h0, 1'b0);
    for (int n = 1; n < 16; n++) begin
      for (int i = 0; i <= n; i++) press(seq_rom[i]);
      if (n < 15) push_all($sformatf("round%0d_done", n), 4'd9, seq_rom[n], 3'b000, 4'(n + 1), 4'h0, 1'b0);
    end
    push_all("won", 4'd10, 4'h4, 3'b101, 4'hF, 4'hF, 1'b0);
    press(4'h2);
    push_all("won_hold", 4'd10, 4'h4, 3'b101, 4'hF, 4'hF, 1'b0);
    // restart and lose in round 1
    jogar = 1'b1;
    tick(1); push_st("restart_prep", 4'd1);
    jogar = 1'b0;
    tick(2); push_all("restart_wait", 4'd9, 4'h0, 3'b000, 4'h0, 4'h0, 1'b0);
    press(4'h1);
    push_all("lose_round0", 4'd9, 4'h1, 3'b000, 4'h1, 4'h0, 1'b0);
    press(4'h1);
    push_all("lose_mid_round1", 4'd9, 4'h1, 3'b000, 4'h1, 4'h1, 1'b0);
    press(4'h4);
    push_all("lost", 4'd11, 4'h4, 3'b011, 4'h1, 4'h1, 1'b0);
    jogar = 1'b1;
    tick(1); push_st("from_lost_prep", 4'd1);
    jogar = 1'b0;
    tick(2); push_all("from_lost_wait", 4'd9, 4'h0, 3'b000, 4'h0, 4'h0, 1'b0);
    press(4'h1);
    reset = 1'b1;
    tick(1); push_all("midgame_reset", 4'd0, 4'h0, 3'b000, 4'h0, 4'h0, 1'b0);
    reset = 1'b0;
`ifdef TIMEOUT_EN
    jogar = 1'b1;
    tick(1);
    jogar = 1'b0;
    tick(2); push_st("to_wait", 4'd9);
    tick(4999); push_st("to_last_wait", 4'd9);
    tick(1); push_all("timeout", 4'd12, 4'h0, 3'b011, 4'h0, 4'h0, 1'b1);
    jogar = 1'b1;
    tick(1); push_all("from_timeout", 4'd1, 4'h0, 3'b000, 4'h0, 4'h0, 1'b0);
    jogar = 1'b0;
`endif
    tick(2);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
